// File: rtl/dma_controller.sv
// Block DMA engine: buffers 4*NUM_BLOCKS device words, then on a CPU command
// requests the bus and writes them out as 4-word blocks, yielding on grant loss.
module dma_controller #(
    parameter int WORD_SIZE    = 16,
    parameter int NUM_BLOCKS   = 3,
    parameter int WRITE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dev_valid,
    input  logic [WORD_SIZE-1:0]   dev_data,
    output logic                   dev_ready,
    output logic                   dma_start_int,
    input  logic                   cmd,
    input  logic [WORD_SIZE-1:0]   cmd_address,
    output logic                   BR,
    input  logic                   BG,
    output logic                   d_writeM,
    output logic [WORD_SIZE-1:0]   d_address,
    output logic [4*WORD_SIZE-1:0] d_data,
    output logic                   dma_end_int,
    output logic [2:0]             dbg_state
);

    localparam int DEPTH  = 4 * NUM_BLOCKS;
    localparam int WCNT_W = $clog2(DEPTH);
    localparam int BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CYC_W  = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DEPTH - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(WRITE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FILL, S_INT, S_WAIT_CMD, S_REQ, S_WRITE, S_DONE, S_END
    } state_t;

    state_t                 state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [BLK_W-1:0]       blk_q, blk_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;
    logic [WORD_SIZE-1:0]   base_q, base_d;
    logic                   dev_ready_q, dev_ready_d;
    logic                   start_int_q, start_int_d;
    logic                   br_q, br_d;
    logic                   wr_q, wr_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [4*WORD_SIZE-1:0] data_q, data_d;
    logic                   end_int_q, end_int_d;
    logic                   mem_we;
    logic [WORD_SIZE-1:0]   mem_q [DEPTH];

    // Device handshake: a word transfers on a rising edge where dev_valid and
    // dev_ready are both high; dev_ready is registered and only high in FILL.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        blk_d   = blk_q;
        cyc_d   = cyc_q;
        base_d  = base_q;
        mem_we  = 1'b0;
        unique case (state_q)
            S_FILL: begin
                if (dev_valid && dev_ready_q) begin
                    mem_we = 1'b1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = S_INT;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_INT: state_d = S_WAIT_CMD;
            S_WAIT_CMD: begin
                if (cmd) begin
                    base_d  = cmd_address;
                    blk_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (BG) begin
                    cyc_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Losing the grant abandons the block; it restarts from cyc 0.
                if (!BG) begin
                    cyc_d   = '0;
                    state_d = S_REQ;
                end else if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (blk_q == BLK_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        blk_d = blk_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!BG) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                wcnt_d  = '0;
                state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        dev_ready_d = (state_d == S_FILL);
        start_int_d = (state_d == S_INT);
        br_d        = (state_d == S_REQ) || (state_d == S_WRITE);
        wr_d        = (state_d == S_WRITE);
        end_int_d   = (state_d == S_END);
        addr_d      = '0;
        data_d      = '0;
        if (state_d == S_WRITE) begin
            addr_d = base_d + (WORD_SIZE'(blk_d) << 2);
            for (int i = 0; i < 4; i++) begin
                data_d[i*WORD_SIZE +: WORD_SIZE] =
                    mem_q[WCNT_W'({blk_d, 2'b00}) + WCNT_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FILL;
            wcnt_q      <= '0;
            blk_q       <= '0;
            cyc_q       <= '0;
            base_q      <= '0;
            dev_ready_q <= 1'b0;
            start_int_q <= 1'b0;
            br_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            end_int_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            blk_q       <= blk_d;
            cyc_q       <= cyc_d;
            base_q      <= base_d;
            dev_ready_q <= dev_ready_d;
            start_int_q <= start_int_d;
            br_q        <= br_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            end_int_q   <= end_int_d;
        end
    end

    // Buffer storage is not reset; only words accepted in FILL are written.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[wcnt_q] <= dev_data;
        end
    end

    // d_data is driven as zero outside writes; the enclosing level tristates it with d_writeM.
    assign dev_ready     = dev_ready_q;
    assign dma_start_int = start_int_q;
    assign BR            = br_q;
    assign d_writeM      = wr_q;
    assign d_address     = addr_q;
    assign d_data        = data_q;
    assign dma_end_int   = end_int_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized transfers.
module tb_dma_controller;

    localparam int W  = 16;
    localparam int NB = 3;
    localparam int WC = 4;
    localparam int NW = 4 * NB;

    logic           clk = 1'b0;
    logic           reset;
    logic           dev_valid;
    logic [W-1:0]   dev_data;
    logic           dev_ready;
    logic           dma_start_int;
    logic           cmd;
    logic [W-1:0]   cmd_address;
    logic           BR;
    logic           bg;
    logic           d_writeM;
    logic [W-1:0]   d_address;
    logic [4*W-1:0] d_data;
    logic           dma_end_int;
    logic [2:0]     dbg_state;

    always #5 clk = ~clk;

    dma_controller #(.WORD_SIZE(W), .NUM_BLOCKS(NB), .WRITE_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .dev_valid(dev_valid), .dev_data(dev_data),
        .dev_ready(dev_ready), .dma_start_int(dma_start_int), .cmd(cmd),
        .cmd_address(cmd_address), .BR(BR), .BG(bg), .d_writeM(d_writeM),
        .d_address(d_address), .d_data(d_data), .dma_end_int(dma_end_int),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases of a transfer plus a single write-progress count
    // (beats completed in the current run), from which block and address follow.
    localparam int PH_FILLING = 0, PH_ANNOUNCE = 1, PH_IDLE = 2, PH_ASK = 3,
                   PH_BURST = 4, PH_RELEASE = 5, PH_FINISH = 6;
    int             ph = PH_FILLING;
    int             nwords = 0;
    int             progress = 0;
    int             mblk = 0;
    logic [W-1:0]   mbuf [NW];
    logic [W-1:0]   mbase = '0;
    logic           e_ready = 1'b0, e_start = 1'b0, e_br = 1'b0, e_wr = 1'b0, e_end = 1'b0;
    logic [W-1:0]   e_addr = '0;
    logic [4*W-1:0] e_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            ph = PH_FILLING; nwords = 0; progress = 0; mbase = '0;
            e_ready = 0; e_start = 0; e_br = 0; e_wr = 0; e_end = 0;
            e_addr = '0; e_data = '0;
        end else begin
            case (ph)
                PH_FILLING: if (e_ready && dev_valid) begin
                    mbuf[nwords] = dev_data;
                    nwords++;
                    if (nwords == NW) ph = PH_ANNOUNCE;
                end
                PH_ANNOUNCE: ph = PH_IDLE;
                PH_IDLE: if (cmd) begin
                    mbase = cmd_address; progress = 0; ph = PH_ASK;
                end
                PH_ASK: if (bg) ph = PH_BURST;
                PH_BURST: begin
                    if (!bg) begin
                        progress = (progress / WC) * WC;
                        ph = PH_ASK;
                    end else begin
                        progress++;
                        if (progress == NB * WC) ph = PH_RELEASE;
                    end
                end
                PH_RELEASE: if (!bg) ph = PH_FINISH;
                default: begin
                    ph = PH_FILLING; nwords = 0;
                end
            endcase
            e_ready = (ph == PH_FILLING);
            e_start = (ph == PH_ANNOUNCE);
            e_br    = (ph == PH_ASK) || (ph == PH_BURST);
            e_wr    = (ph == PH_BURST);
            e_end   = (ph == PH_FINISH);
            e_addr  = '0;
            e_data  = '0;
            if (ph == PH_BURST) begin
                mblk   = progress / WC;
                e_addr = mbase + W'(4 * mblk);
                e_data = {mbuf[4*mblk+3], mbuf[4*mblk+2], mbuf[4*mblk+1], mbuf[4*mblk]};
            end
        end
    end

    logic [W-1:0]   addr_log[$];
    logic [4*W-1:0] data_log[$];
    logic [W-1:0]   exp_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("dev_ready", dev_ready, e_ready);
            check("dma_start_int", dma_start_int, e_start);
            check("BR", BR, e_br);
            check("d_writeM", d_writeM, e_wr);
            check("d_address", d_address, e_addr);
            check("d_data", d_data, e_data);
            check("dma_end_int", dma_end_int, e_end);
            if (d_writeM) begin
                addr_log.push_back(d_address);
                data_log.push_back(d_data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill(input logic [W-1:0] first, input bit rnd);
        int got = 0;
        int budget = 400;
        while (got < NW && budget > 0) begin
            dev_valid   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            dev_data    = rnd ? W'($urandom) : first + W'(got);
            cmd         = ($urandom_range(0, 4) == 0);
            cmd_address = W'($urandom);
            if (dev_valid && dev_ready) got++;
            tick();
            budget--;
        end
        cmd = 1'b0;
        check("fill_count", got, NW);
        check("start_int_after_fill", dma_start_int, 1);
        check("ready_low_after_fill", dev_ready, 0);
        tick();
        check("start_int_one_cycle", dma_start_int, 0);
    endtask

    task automatic transfer(input logic [W-1:0] addr, input int grant_delay, input int steal_at,
                            input int regrant_gap, input bit rnd, input int reset_at);
        int  budget = 400;
        int  wr_seen = 0;
        int  wait_cnt = 0;
        int  gap = 0;
        int  hold = 2;
        bit  stolen = 1'b0;
        bg = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            dev_valid = ($urandom_range(0, 1) == 1);
            tick();
        end
        cmd = 1'b1;
        cmd_address = addr;
        tick();
        cmd = 1'b0;
        check("br_after_cmd", BR, 1);
        addr_log.delete();
        data_log.delete();
        while (!dma_end_int && budget > 0) begin
            dev_valid = ($urandom_range(0, 1) == 1);
            dev_data  = W'(16'hDEAD);
            if (d_writeM) wr_seen++;
            if (reset_at >= 0 && d_writeM && wr_seen == reset_at + 1) begin
                reset = 1'b1;
                dev_valid = 1'b0;
                tick();
                reset = 1'b0;
                bg = 1'b0;
                check("rst_writeM", d_writeM, 0);
                check("rst_BR", BR, 0);
                check("rst_address", d_address, 0);
                check("rst_data", d_data, 0);
                check("rst_ready", dev_ready, 0);
                tick();
                check("rst_ready_after", dev_ready, 1);
                return;
            end
            if (rnd) begin
                cmd = ($urandom_range(0, 7) == 0);
                cmd_address = W'($urandom);
                if (BR) bg = ($urandom_range(0, 5) != 0);
                else if (bg) bg = ($urandom_range(0, 2) != 0);
            end else if (steal_at >= 0 && !stolen && d_writeM && wr_seen == steal_at + 1) begin
                bg = 1'b0;
                stolen = 1'b1;
                gap = regrant_gap;
            end else if (stolen && !bg && BR) begin
                gap--;
                if (gap <= 0) bg = 1'b1;
            end else if (BR && !bg) begin
                if (wait_cnt >= grant_delay) bg = 1'b1;
                else wait_cnt++;
            end else if (!BR && bg) begin
                if (hold == 0) bg = 1'b0;
                else hold--;
            end
            tick();
            budget--;
        end
        cmd = 1'b0;
        check("end_int_seen", dma_end_int, 1);
        bg = 1'b0;
        tick();
        check("end_int_one_cycle", dma_end_int, 0);
        check("ready_after_end", dev_ready, 1);
    endtask

    task automatic compare_log(input string name);
        check({name, "_len"}, addr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++) begin
            check({name, "_addr"}, addr_log[i], exp_q[i]);
        end
    endtask

    task automatic push_block(input logic [W-1:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(a);
    endtask

    initial begin
        reset = 1'b1; dev_valid = 1'b0; dev_data = '0;
        cmd = 1'b0; cmd_address = '0; bg = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        chk_en = 1'b1;
        check("reset_ready", dev_ready, 0);
        check("reset_BR", BR, 0);
        check("reset_writeM", d_writeM, 0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", dev_ready, 1);

        // Plain transfer of 0x0001..0x000C to 0x0100.
        fill(16'h0001, 1'b0);
        transfer(16'h0100, 1, -1, 0, 1'b0, -1);
        exp_q.delete();
        push_block(16'h0100, WC); push_block(16'h0104, WC); push_block(16'h0108, WC);
        compare_log("plain");
        if (data_log.size() > 0) check("first_d_data", data_log[0], 64'h0004_0003_0002_0001);

        // Grant stolen at cyc 2 of block 1, returned 3 cycles later.
        fill(16'h0001, 1'b0);
        transfer(16'h0100, 1, 6, 3, 1'b0, -1);
        exp_q.delete();
        push_block(16'h0100, WC); push_block(16'h0104, 3);
        push_block(16'h0104, WC); push_block(16'h0108, WC);
        compare_log("steal");
        if (data_log.size() > 7) check("restart_d_data", data_log[7], 64'h0008_0007_0006_0005);

        // Reset in the middle of block 1, then a fresh transfer wrapping the address space.
        fill(16'h0001, 1'b0);
        transfer(16'h0100, 1, -1, 0, 1'b0, 5);
        fill(16'h0011, 1'b0);
        transfer(16'hFFFC, 0, -1, 0, 1'b0, -1);
        exp_q.delete();
        push_block(16'hFFFC, WC); push_block(16'h0000, WC); push_block(16'h0004, WC);
        compare_log("wrap");
        if (data_log.size() > 0) check("wrap_d_data", data_log[0], 64'h0014_0013_0012_0011);

        repeat (8) begin
            fill(W'($urandom), 1'b1);
            transfer(W'($urandom), $urandom_range(0, 3), -1, 0, 1'b1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
